// File: rtl/count_uart_tx.sv
// UART reporter for the 4-bit counter: each new value is sent as an ASCII hex digit plus LF.
// One pending slot; a value overwritten before transmission raises a one-cycle overrun pulse.
module count_uart_tx #(
    parameter int unsigned BAUD_DIV = 104
) (
    input  logic       clk_in,
    input  logic       rstn,
    input  logic [3:0] data,
    output logic       tx,
    output logic       busy,
    output logic       overrun
);

    localparam int unsigned    CntW   = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(BAUD_DIV - 1);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] baud_q, baud_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic            char_idx_q, char_idx_d;
    logic [3:0]      data_q, data_d;
    logic [3:0]      pend_q, pend_d;
    logic            pend_valid_q, pend_valid_d;
    logic            tx_q, tx_d;
    logic            busy_q, busy_d;
    logic            ovr_q, ovr_d;

    logic baud_end;
    logic consume;
    logic changed;

    function automatic logic [7:0] hex_ascii(input logic [3:0] v);
        if (v < 4'd10) begin
            return 8'h30 + {4'b0000, v};
        end else begin
            return 8'h37 + {4'b0000, v};
        end
    endfunction

    assign baud_end = (baud_q == CntMax);
    assign consume  = (state_q == StIdle) && pend_valid_q;
    assign changed  = (data != data_q);

    // Change detect and the single pending slot
    always_comb begin
        data_d       = data_q;
        pend_d       = pend_q;
        pend_valid_d = pend_valid_q;
        ovr_d        = 1'b0;
        if (changed) begin
            data_d       = data;
            pend_d       = data;
            pend_valid_d = 1'b1;
            ovr_d        = pend_valid_q && !consume;
        end else if (consume) begin
            pend_valid_d = 1'b0;
        end
    end

    // tx_d/busy_d follow the next state so both outputs come straight from flops
    always_comb begin
        state_d    = state_q;
        baud_d     = baud_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        char_idx_d = char_idx_q;
        tx_d       = tx_q;
        busy_d     = busy_q;
        case (state_q)
            StIdle: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                baud_d = '0;
                if (pend_valid_q) begin
                    shift_d    = hex_ascii(pend_q);
                    char_idx_d = 1'b0;
                    state_d    = StStart;
                    tx_d       = 1'b0;
                    busy_d     = 1'b1;
                end
            end
            StStart: begin
                if (baud_end) begin
                    baud_d  = '0;
                    bit_d   = 3'd0;
                    state_d = StData;
                    tx_d    = shift_q[0];
                end else begin
                    baud_d = baud_q + CntW'(1);
                end
            end
            StData: begin
                if (baud_end) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        state_d = StStop;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d = bit_q + 3'd1;
                        tx_d  = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q + CntW'(1);
                end
            end
            StStop: begin
                if (baud_end) begin
                    baud_d = '0;
                    if (!char_idx_q) begin
                        char_idx_d = 1'b1;
                        shift_d    = 8'h0A;
                        state_d    = StStart;
                        tx_d       = 1'b0;
                    end else begin
                        state_d = StIdle;
                        tx_d    = 1'b1;
                        busy_d  = 1'b0;
                    end
                end else begin
                    baud_d = baud_q + CntW'(1);
                end
            end
            default: begin
                state_d = StIdle;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge rstn) begin
        if (!rstn) begin
            state_q      <= StIdle;
            baud_q       <= '0;
            bit_q        <= 3'd0;
            shift_q      <= 8'h00;
            char_idx_q   <= 1'b0;
            data_q       <= 4'd0;
            pend_q       <= 4'd0;
            pend_valid_q <= 1'b0;
            tx_q         <= 1'b1;
            busy_q       <= 1'b0;
            ovr_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            baud_q       <= baud_d;
            bit_q        <= bit_d;
            shift_q      <= shift_d;
            char_idx_q   <= char_idx_d;
            data_q       <= data_d;
            pend_q       <= pend_d;
            pend_valid_q <= pend_valid_d;
            tx_q         <= tx_d;
            busy_q       <= busy_d;
            ovr_q        <= ovr_d;
        end
    end

    assign tx      = tx_q;
    assign busy    = busy_q;
    assign overrun = ovr_q;

endmodule

// File: tb/tb_count_uart_tx.sv
// Directed bench for count_uart_tx: UART line monitors decode the serial stream while
// one initial block steps through the scenarios and checks with immediate assertions.
module tb_count_uart_tx;

    localparam int Bd1 = 4;
    localparam int Bd2 = 2;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic [3:0] data1 = 4'd0;
    logic [3:0] data2 = 4'd0;
    logic       tx1, busy1, ovr1;
    logic       tx2, busy2, ovr2;

    always #5 clk = ~clk;

    count_uart_tx #(.BAUD_DIV(Bd1)) dut1 (
        .clk_in (clk),
        .rstn   (rstn),
        .data   (data1),
        .tx     (tx1),
        .busy   (busy1),
        .overrun(ovr1)
    );

    count_uart_tx #(.BAUD_DIV(Bd2)) dut2 (
        .clk_in (clk),
        .rstn   (rstn),
        .data   (data2),
        .tx     (tx2),
        .busy   (busy2),
        .overrun(ovr2)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] q1[$];
    logic [7:0] q2[$];
    int rd1 = 0;
    int rd2 = 0;

    // Line statistics for dut1, sampled on the falling edge
    int ovr_cnt = 0, tx_low_cnt = 0, hi_run = 0, lo_run = 0, last_hi = 0, last_lo = 0;
    always @(negedge clk) begin
        if (ovr1 === 1'b1) ovr_cnt <= ovr_cnt + 1;
        if (tx1 === 1'b0) tx_low_cnt <= tx_low_cnt + 1;
        if (busy1 === 1'b1) begin
            hi_run <= hi_run + 1;
            if (lo_run != 0) last_lo <= lo_run;
            lo_run <= 0;
        end else begin
            lo_run <= lo_run + 1;
            if (hi_run != 0) last_hi <= hi_run;
            hi_run <= 0;
        end
    end

    // Free-running counter for dut2 (1-bit prescaler), frozen once it wraps back to 0
    logic cnt_en = 1'b0;
    logic cnt_done = 1'b0;
    logic presc = 1'b0;
    always @(posedge clk) begin
        if (cnt_en && !cnt_done) begin
            presc <= ~presc;
            if (presc) begin
                data2 <= data2 + 4'd1;
                if (data2 == 4'd15) cnt_done <= 1'b1;
            end
        end
    end

    function automatic logic line(input bit sel);
        return sel ? tx2 : tx1;
    endfunction

    // Decode one 8N1 frame; a reset seen at a sample point abandons the frame
    task automatic rx_frame(input bit sel, input int bd, output logic [7:0] ch, output bit ok);
        ok = 1'b1;
        ch = 8'h00;
        while (line(sel) !== 1'b0 || rstn !== 1'b1) @(negedge clk);
        repeat (bd / 2) @(negedge clk);
        if (rstn !== 1'b1 || line(sel) !== 1'b0) begin
            ok = 1'b0;
            return;
        end
        for (int j = 0; j < 9; j++) begin
            repeat (bd) @(negedge clk);
            if (rstn !== 1'b1) begin
                ok = 1'b0;
                return;
            end
            if (j < 8) ch[j] = line(sel);
            else if (line(sel) !== 1'b1) ch = 8'hEE;
        end
    endtask

    always begin : mon1
        logic [7:0] c;
        bit ok;
        rx_frame(1'b0, Bd1, c, ok);
        if (ok) q1.push_back(c);
    end

    always begin : mon2
        logic [7:0] c;
        bit ok;
        rx_frame(1'b1, Bd2, c, ok);
        if (ok) q2.push_back(c);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic get_char(input bit sel, input string tag, output logic [7:0] ch);
        int waited = 0;
        ch = 8'h00;
        while ((sel ? q2.size() : q1.size()) <= (sel ? rd2 : rd1) && waited < 400) begin
            @(negedge clk);
            waited++;
        end
        check({tag, "_timeout"}, 32'(waited < 400), 32'd1);
        if (!sel && q1.size() > rd1) begin
            ch = q1[rd1];
            rd1++;
        end else if (sel && q2.size() > rd2) begin
            ch = q2[rd2];
            rd2++;
        end
    endtask

    task automatic expect_msg(input bit sel, input logic [7:0] c0, input string tag);
        logic [7:0] ch;
        get_char(sel, tag, ch);
        check({tag, "_digit"}, 32'(ch), 32'(c0));
        get_char(sel, tag, ch);
        check({tag, "_lf"}, 32'(ch), 32'h0A);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int base;
        int w;
        int n;
        logic [3:0] vals[3];
        logic [7:0] exps[3];
        vals = '{4'd9, 4'd10, 4'd15};
        exps = '{8'h39, 8'h41, 8'h46};

        // Reset state and quiet line with data held at 0
        repeat (3) @(negedge clk);
        check("rst_tx", 32'(tx1), 32'd1);
        check("rst_busy", 32'(busy1), 32'd0);
        check("rst_overrun", 32'(ovr1), 32'd0);
        rstn = 1'b1;
        base = tx_low_cnt;
        repeat (60) @(negedge clk);
        check("idle_no_start", 32'(tx_low_cnt - base), 32'd0);
        check("idle_busy", 32'(busy1), 32'd0);
        check("idle_no_chars", 32'(q1.size()), 32'd0);

        // 0 -> 5: two-edge latency, "5\n", busy 80 cycles
        @(negedge clk);
        data1 = 4'd5;
        @(posedge clk);
        #1;
        check("lat_edge_e_tx", 32'(tx1), 32'd1);
        @(posedge clk);
        #1;
        check("lat_edge_e1_tx", 32'(tx1), 32'd0);
        check("lat_edge_e1_busy", 32'(busy1), 32'd1);
        expect_msg(1'b0, 8'h35, "msg5");
        repeat (10) @(negedge clk);
        check("busy_len_80", 32'(last_hi), 32'd80);

        // Digit/letter boundary and uppercase letters
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            data1 = vals[i];
            expect_msg(1'b0, exps[i], $sformatf("hex_%0d", vals[i]));
            repeat (20) @(negedge clk);
        end

        // Rapid 1 -> 2 -> 3 -> 4: refill on consume edge, then two overwrites
        base = ovr_cnt;
        @(negedge clk);
        data1 = 4'd1;
        @(negedge clk);
        data1 = 4'd2;
        @(negedge clk);
        data1 = 4'd3;
        @(negedge clk);
        data1 = 4'd4;
        expect_msg(1'b0, 8'h31, "ovr_msg1");
        expect_msg(1'b0, 8'h34, "ovr_msg4");
        repeat (10) @(negedge clk);
        check("overrun_pulses", 32'(ovr_cnt - base), 32'd2);
        check("gap_busy_low", 32'(last_lo), 32'd1);
        check("second_busy_len", 32'(last_hi), 32'd80);

        // Reset in the middle of char0's data bits (0x33, bit 2 is a 0)
        @(negedge clk);
        data1 = 4'd3;
        w = 0;
        while (tx1 !== 1'b0 && w < 20) begin
            @(negedge clk);
            w++;
        end
        check("rst_frame_started", 32'(tx1), 32'd0);
        repeat (12) @(negedge clk);
        check("mid_data_bit2", 32'(tx1), 32'd0);
        #2;
        rstn = 1'b0;
        #1;
        check("async_rst_tx", 32'(tx1), 32'd1);
        check("async_rst_busy", 32'(busy1), 32'd0);
        check("async_rst_overrun", 32'(ovr1), 32'd0);
        data1 = 4'd7;
        repeat (10) @(negedge clk);
        rstn = 1'b1;
        expect_msg(1'b0, 8'h37, "after_rst");
        repeat (100) @(negedge clk);
        check("no_residue", 32'(q1.size() - rd1), 32'd0);

        // Counter-driven dut2: wrap 15 -> 0 ends with "0\n", never a repeat
        cnt_en = 1'b1;
        repeat (500) @(negedge clk);
        check("cnt_done", 32'(cnt_done), 32'd1);
        check("cnt_idle", 32'(busy2), 32'd0);
        n = q2.size();
        check("cnt_even_len", 32'(n % 2), 32'd0);
        check("cnt_min_msgs", 32'(n >= 4), 32'd1);
        if (n >= 2) begin
            check("cnt_first", 32'(q2[0]), 32'h31);
            check("cnt_last_zero", 32'(q2[n - 2]), 32'h30);
            for (int i = 0; i + 1 < n; i += 2) begin
                check($sformatf("cnt_lf_%0d", i / 2), 32'(q2[i + 1]), 32'h0A);
                if (i >= 2) begin
                    check($sformatf("cnt_norep_%0d", i / 2), 32'(q2[i] != q2[i - 2]), 32'd1);
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
